// File: rtl/maxval_axil_engine.sv
// Max-value accelerator: AXI4-Lite register block (CTRL/STATUS/RESULT) plus a BRAM
// port-B engine that scans DEPTH words and writes their unsigned maximum back to word 0.

module maxval_axil_engine #(
    parameter int DEPTH   = 2048,
    parameter int BRAM_AW = 11,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [DATA_W-1:0]  s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [3:0]         s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [DATA_W-1:0]  s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [DATA_W-1:0]  bram_din,
    input  logic [DATA_W-1:0]  bram_dout
);
    localparam int CW = BRAM_AW + 1;
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_SCAN, ST_WRITE, ST_DONE} state_t;

    state_t              state_r, state_n;
    logic [CW-1:0]       cnt_r, cnt_n;
    logic [DATA_W-1:0]   max_r, max_n, result_r, result_n, rdata_r, rd_mux_s;
    logic                start_r, start_n, done_r, done_n;
    logic                aw_held_r, aw_held_n, w_held_r, w_held_n, bvalid_r, bvalid_n;
    logic                awready_r, wready_r, arready_r, rvalid_r, rvalid_n, commit_s;
    logic [1:0]          aw_addr_r;
    logic                w_data0_r, w_strb0_r;
    logic                bram_en_r, bram_en_n;
    logic [3:0]          bram_we_r, bram_we_n;
    logic [BRAM_AW-1:0]  bram_addr_r, bram_addr_n;
    logic [DATA_W-1:0]   bram_din_r, bram_din_n;
    logic                unused_s;

    assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[DATA_W-1:1], s_axi_wstrb[3:1]};

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = 2'b00;
    assign bram_en       = bram_en_r;
    assign bram_we       = bram_we_r;
    assign bram_addr     = bram_addr_r;
    assign bram_din      = bram_din_r;

    // Write channel: AW and W are parked independently; the register commits once both are held.
    always_comb begin
        aw_held_n = aw_held_r;
        w_held_n  = w_held_r;
        bvalid_n  = bvalid_r;
        commit_s  = 1'b0;
        start_n   = start_r;
        if (s_axi_awvalid && awready_r) aw_held_n = 1'b1;
        else                            aw_held_n = aw_held_r;
        if (s_axi_wvalid && wready_r) w_held_n = 1'b1;
        else                          w_held_n = w_held_r;
        if (aw_held_r && w_held_r) begin
            commit_s  = 1'b1;
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
        end else if (bvalid_r && s_axi_bready) begin
            bvalid_n = 1'b0;
        end else begin
            bvalid_n = bvalid_r;
        end
        if (commit_s && (aw_addr_r == 2'd0) && w_strb0_r) start_n = w_data0_r;
        else                                               start_n = start_r;
    end

    // Read channel state and register read mux.
    always_comb begin
        rvalid_n = rvalid_r;
        if (s_axi_arvalid && arready_r)   rvalid_n = 1'b1;
        else if (rvalid_r && s_axi_rready) rvalid_n = 1'b0;
        else                               rvalid_n = rvalid_r;
        case (s_axi_araddr[3:2])
            2'd0:    rd_mux_s = {{(DATA_W-1){1'b0}}, start_r};
            2'd1:    rd_mux_s = {{(DATA_W-1){1'b0}}, done_r};
            2'd2:    rd_mux_s = result_r;
            default: rd_mux_s = {DATA_W{1'b0}};
        endcase
    end

    // Scan FSM: BRAM outputs are computed one cycle ahead so they leave on registers.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        max_n       = max_r;
        result_n    = result_r;
        bram_en_n   = 1'b0;
        bram_we_n   = 4'h0;
        bram_addr_n = {BRAM_AW{1'b0}};
        bram_din_n  = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start_r) begin
                    state_n   = ST_READ;
                    bram_en_n = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                state_n     = ST_SCAN;
                cnt_n       = {CW{1'b0}};
                bram_en_n   = 1'b1;
                bram_addr_n = {{(BRAM_AW-1){1'b0}}, 1'b1};
            end
            ST_SCAN: begin
                // bram_dout holds word cnt_r; strict compare keeps the first of equal values
                if ((cnt_r == {CW{1'b0}}) || (bram_dout > max_r)) max_n = bram_dout;
                else                                               max_n = max_r;
                cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_C) begin
                    state_n    = ST_WRITE;
                    bram_en_n  = 1'b1;
                    bram_we_n  = 4'hF;
                    bram_din_n = max_n;
                end else begin
                    state_n     = ST_SCAN;
                    bram_en_n   = ((cnt_r + CW'(2)) < DEPTH_C);
                    bram_addr_n = BRAM_AW'(cnt_r + CW'(2));
                end
            end
            ST_WRITE: begin
                state_n  = ST_DONE;
                result_n = max_r;
            end
            ST_DONE: begin
                if (!start_r) state_n = ST_IDLE;
                else          state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
        done_n = (state_n == ST_DONE);
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            max_r       <= {DATA_W{1'b0}};
            result_r    <= {DATA_W{1'b0}};
            start_r     <= 1'b0;
            done_r      <= 1'b0;
            aw_held_r   <= 1'b0;
            w_held_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            arready_r   <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
            aw_addr_r   <= 2'd0;
            w_data0_r   <= 1'b0;
            w_strb0_r   <= 1'b0;
            bram_en_r   <= 1'b0;
            bram_we_r   <= 4'h0;
            bram_addr_r <= {BRAM_AW{1'b0}};
            bram_din_r  <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            max_r       <= max_n;
            result_r    <= result_n;
            start_r     <= start_n;
            done_r      <= done_n;
            aw_held_r   <= aw_held_n;
            w_held_r    <= w_held_n;
            bvalid_r    <= bvalid_n;
            awready_r   <= ~aw_held_n & ~bvalid_n;
            wready_r    <= ~w_held_n & ~bvalid_n;
            arready_r   <= ~rvalid_n;
            rvalid_r    <= rvalid_n;
            bram_en_r   <= bram_en_n;
            bram_we_r   <= bram_we_n;
            bram_addr_r <= bram_addr_n;
            bram_din_r  <= bram_din_n;
            if (s_axi_awvalid && awready_r) aw_addr_r <= s_axi_awaddr[3:2];
            if (s_axi_wvalid && wready_r) begin
                w_data0_r <= s_axi_wdata[0];
                w_strb0_r <= s_axi_wstrb[0];
            end
            if (s_axi_arvalid && arready_r) rdata_r <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_maxval_axil_engine.sv
// Directed self-checking bench for maxval_axil_engine with a behavioural BRAM on port B.

module tb_maxval_axil_engine;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  awaddr, araddr, wstrb, bram_we;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, bram_en;
    logic [31:0] wdata, rdata, bram_din, bram_dout;
    logic [1:0]  bresp, rresp;
    logic [AW-1:0] bram_addr;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] img [0:DEPTH-1];
    logic        load_req = 1'b0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    maxval_axil_engine #(.DEPTH(DEPTH), .BRAM_AW(AW), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM port B model (read-first) plus a monitor of engine writes
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (bram_en) begin
            if (bram_we == 4'hF) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
        if (bram_en && bram_we == 4'hF) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end
    end

    task automatic load_mem();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output int c0);
        bit aw_ok, w_ok;
        int n;
        aw_ok = 0; w_ok = 0; n = 0; c0 = -1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            @(negedge clk);
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            @(posedge clk); #1;
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
            n++;
        end
        bready = 1'b1; n = 0;
        while (c0 < 0 && n < 50) begin
            @(negedge clk);
            if (bvalid) begin
                c0 = cyc;
                checks++;
                if (bresp !== 2'b00) begin errors++; $display("FAIL bresp got=%b want=00", bresp); end
            end
            @(posedge clk); #1;
            n++;
        end
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (c0 < 0) begin errors++; $display("FAIL write_timeout addr=%h got=no_bvalid want=bvalid", a); end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit ar_ok, got;
        int n;
        ar_ok = 0; got = 0; n = 0; d = 32'hXXXXXXXX;
        araddr = a; arvalid = 1'b1;
        while (!ar_ok && n < 50) begin
            @(negedge clk);
            if (arready) ar_ok = 1;
            @(posedge clk); #1;
            if (ar_ok) arvalid = 1'b0;
            n++;
        end
        rready = 1'b1; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (rvalid) begin
                got = 1; d = rdata;
                checks++;
                if (rresp !== 2'b00) begin errors++; $display("FAIL rresp got=%b want=00", rresp); end
            end
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0; arvalid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL read_timeout addr=%h got=no_rvalid want=rvalid", a); end
    endtask

    task automatic wait_done();
        logic [31:0] v;
        int n;
        v = 32'h0; n = 0;
        while (v !== 32'h1 && n < 1500) begin
            axi_read(4'h4, v);
            n++;
        end
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL done_timeout got=%h want=00000001", v); end
    endtask

    task automatic do_run(output logic [31:0] res);
        int c;
        axi_write(4'h0, 32'h1, 4'hF, c);
        wait_done();
        axi_read(4'h8, res);
        axi_write(4'h0, 32'h0, 4'hF, c);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rstn = 1'b0;
        awaddr = 4'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 4'h0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bram_en, bram_we} !== 10'h0)
            begin errors++; $display("FAIL reset_outputs got=%b want=0", {awready, wready, arready, bvalid, rvalid, bram_en, bram_we}); end
        @(posedge clk); #1 rstn = 1'b1;
        axi_read(4'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", v); end
        axi_read(4'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got=%h want=0", v); end
        axi_read(4'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", v); end
    endtask

    task automatic test_reg_access();
        logic [31:0] v;
        int c;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'(i * 3);
        load_mem();
        axi_write(4'h0, 32'h1, 4'hF, c);
        axi_read(4'h0, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL ctrl_rb got=%h want=1", v); end
        axi_read(4'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL status_busy got=%h want=0", v); end
        axi_read(4'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL result_busy got=%h want=0", v); end
        axi_read(4'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h want=0", v); end
        axi_write(4'h4, 32'hFF, 4'hF, c);
        axi_read(4'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL status_ro got=%h want=0", v); end
        axi_write(4'h0, 32'h0, 4'h0, c);
        axi_read(4'h0, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL ctrl_wstrb got=%h want=1", v); end
        wait_done();
        axi_read(4'h8, v);
        checks++; if (v !== 32'd6141) begin errors++; $display("FAIL ramp_max got=%h want=%h", v, 32'd6141); end
        axi_write(4'h0, 32'h0, 4'hF, c);
    endtask

    task automatic test_max_run();
        logic [31:0] v;
        int c0, c1, w0;
        for (int i = 0; i < DEPTH - 1; i++) img[i] = $urandom;
        img[DEPTH-1] = 32'hFFFF_FFFF;
        load_mem();
        w0 = wr_cnt;
        axi_write(4'h0, 32'h1, 4'hF, c0);
        while (cyc < c0 + DEPTH + 3) begin @(posedge clk); #1; end
        axi_read(4'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL done_latency got=%h want=1", v); end
        checks++;
        if (wr_cnt !== w0 + 1 || wr_cyc !== c0 + DEPTH + 2)
            begin errors++; $display("FAIL write_timing got=cnt%0d@%0d want=cnt%0d@%0d", wr_cnt, wr_cyc, w0 + 1, c0 + DEPTH + 2); end
        checks++; if (mem[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL word0_max got=%h want=ffffffff", mem[0]); end
        axi_read(4'h8, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL result_max got=%h want=ffffffff", v); end
        axi_write(4'h0, 32'h0, 4'hF, c1);
        axi_read(4'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL done_clear got=%h want=0", v); end
    endtask

    task automatic test_signed();
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom & 32'h7FFF_FFFF;
        img[5] = 32'h8000_0000;
        load_mem();
        do_run(v);
        checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL signed_trap got=%h want=80000000", v); end
        checks++; if (mem[0] !== 32'h8000_0000) begin errors++; $display("FAIL signed_word0 got=%h want=80000000", mem[0]); end
    endtask

    task automatic test_zero_and_first();
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'h0;
        load_mem();
        do_run(v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL zero_result got=%h want=0", v); end
        checks++; if (mem[0] !== 32'h0) begin errors++; $display("FAIL zero_word0 got=%h want=0", mem[0]); end
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom_range(32'h1233, 32'h0);
        img[0] = 32'h1234;
        img[7] = 32'h1234;
        load_mem();
        do_run(v);
        checks++; if (v !== 32'h1234) begin errors++; $display("FAIL first_result got=%h want=1234", v); end
        checks++; if (mem[0] !== 32'h1234) begin errors++; $display("FAIL first_word0 got=%h want=1234", mem[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        @(posedge clk); #1;
        wdata = 32'hDEAD; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        checks++; if (wready !== 1'b1) begin errors++; $display("FAIL w_first_ready got=%b want=1", wready); end
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wready, awready, bvalid} !== 3'b010) begin errors++; $display("FAIL w_held got=%b want=010", {wready, awready, bvalid}); end
        @(posedge clk); #1;
        awaddr = 4'hC; awvalid = 1'b1; araddr = 4'h8; arvalid = 1'b1;
        @(negedge clk);
        checks++; if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL aw_ar_ready got=%b want=11", {awready, arready}); end
        @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_hold k=%0d got=%b want=1", k, bvalid); end
            end
            if (k <= 5) begin
                checks++;
                if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h1234})
                    begin errors++; $display("FAIL rdata_hold k=%0d got=%b/%h want=1/1234", k, rvalid, rdata); end
            end
            if (k == 6) begin
                checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got=%b want=0", rvalid); end
            end
            @(posedge clk); #1;
            if (k == 4) rready = 1'b1;
            if (k == 5) rready = 1'b0;
        end
        bready = 1'b1;
        @(negedge clk);
        checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL b_complete got=%b want=100", {bvalid, bresp}); end
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        checks++; if ({bvalid, awready} !== 2'b01) begin errors++; $display("FAIL b_idle got=%b want=01", {bvalid, awready}); end
        axi_read(4'h8, v);
        checks++; if (v !== 32'h1234) begin errors++; $display("FAIL unmapped_wr got=%h want=1234", v); end
        axi_read(4'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_untouched got=%h want=0", v); end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] v;
        int c0, w0;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'(i + 1);
        img[0] = 32'h100;
        load_mem();
        w0 = wr_cnt;
        axi_write(4'h0, 32'h1, 4'hF, c0);
        while (cyc < c0 + 1 + 1000) begin @(posedge clk); #1; end
        checks++;
        if ({bram_en, bram_addr} !== {1'b1, 11'd1000}) begin errors++; $display("FAIL scan_pos got=%b/%0d want=1/1000", bram_en, bram_addr); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bram_en, bram_we} !== 10'h0)
            begin errors++; $display("FAIL midscan_reset got=%b want=0", {awready, wready, arready, bvalid, rvalid, bram_en, bram_we}); end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== w0 || mem[0] !== 32'h100) begin errors++; $display("FAIL no_write got=%0d/%h want=%0d/100", wr_cnt, mem[0], w0); end
        axi_read(4'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_status got=%h want=0", v); end
        axi_read(4'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h want=0", v); end
        axi_read(4'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_result got=%h want=0", v); end
        do_run(v);
        checks++; if (v !== 32'd2048) begin errors++; $display("FAIL rerun_result got=%h want=%h", v, 32'd2048); end
        checks++; if (mem[0] !== 32'd2048) begin errors++; $display("FAIL rerun_word0 got=%h want=%h", mem[0], 32'd2048); end
    endtask

    initial begin
        test_reset();
        test_reg_access();
        test_max_run();
        test_signed();
        test_zero_and_first();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
